// File: rtl/frame_writer_pkg.sv
// Shared types and colour constants for the framebuffer test-pattern writer.
package frame_writer_pkg;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    BARS     = 2'd1,
    GRADIENT = 2'd2,
    CHECKER  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [23:0] GRAY        = 24'h808080;
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Colour of vertical bar idx, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      3'd7:    bar_color = BAR_BLACK;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Pure combinational pixel colour lookup for one (x, y) position.
// Only the low coordinate bits are needed by any pattern; the bar index
// comes from the caller's sub-counter so no divider is required here.
module pattern_gen
  import frame_writer_pkg::*;
(
  input  logic [7:0]  x_lo,
  input  logic [7:0]  y_lo,
  input  logic [2:0]  bar_idx,
  input  pattern_e    pattern,
  output logic [23:0] rgb
);

  // Select the colour for the requested pattern.
  always_comb begin
    rgb = 24'h000000;
    case (pattern)
      SOLID:    rgb = GRAY;
      BARS:     rgb = bar_color(bar_idx);
      GRADIENT: rgb = {x_lo, y_lo, 8'h00};
      CHECKER: begin
        if ((x_lo[4] ^ y_lo[4]) == 1'b1) begin
          rgb = 24'hFFFFFF;
        end else begin
          rgb = 24'h000000;
        end
      end
      default:  rgb = GRAY;
    endcase
  end

endmodule

// File: rtl/frame_writer.sv
// Avalon-MM write master that fills a framebuffer with a test pattern,
// one 32-bit word per pixel, in raster order starting at BASE_ADDR.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        cont,
  input  logic [1:0]  pattern_sel,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_count
);

  localparam int XW    = $clog2(HDISP);
  localparam int YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BAR_W = HDISP / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  state_e        state_r;
  pattern_e      pattern_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [2:0]    bar_idx_r;
  logic [BW-1:0] bar_cnt_r;
  logic          after_done_r;

  logic          accept_s;
  logic          last_pixel_s;
  logic          go_s;
  logic [XW-1:0] next_x_s;
  logic [YW-1:0] next_y_s;
  logic [2:0]    next_bar_idx_s;
  logic [BW-1:0] next_bar_cnt_s;
  pattern_e      gen_pattern_s;
  logic [23:0]   rgb_s;

  assign avm_byteenable = 4'hF;
  assign accept_s       = avm_write & ~avm_waitrequest;
  assign last_pixel_s   = (x_r == X_LAST) && (y_r == Y_LAST);
  assign go_s           = (state_r == IDLE) && (start || (cont && after_done_r));

  // Coordinates of the pixel to present next; in IDLE this is (0,0) with
  // the live pattern select so the first word is ready on the start edge.
  always_comb begin
    next_x_s       = x_r;
    next_y_s       = y_r;
    next_bar_idx_s = bar_idx_r;
    next_bar_cnt_s = bar_cnt_r;
    gen_pattern_s  = pattern_r;
    if (state_r == IDLE) begin
      next_x_s       = '0;
      next_y_s       = '0;
      next_bar_idx_s = 3'd0;
      next_bar_cnt_s = '0;
      gen_pattern_s  = pattern_e'(pattern_sel);
    end else if (x_r == X_LAST) begin
      next_x_s       = '0;
      next_y_s       = y_r + YW'(1);
      next_bar_idx_s = 3'd0;
      next_bar_cnt_s = '0;
    end else begin
      next_x_s = x_r + XW'(1);
      if (bar_cnt_r == BAR_LAST) begin
        next_bar_cnt_s = '0;
        next_bar_idx_s = bar_idx_r + 3'd1;
      end else begin
        next_bar_cnt_s = bar_cnt_r + BW'(1);
      end
    end
  end

  pattern_gen u_pattern_gen (
    .x_lo    (8'(next_x_s)),
    .y_lo    (8'(next_y_s)),
    .bar_idx (next_bar_idx_s),
    .pattern (gen_pattern_s),
    .rgb     (rgb_s)
  );

  // Frame FSM, pixel counters and registered Avalon master outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r       <= IDLE;
      pattern_r     <= SOLID;
      x_r           <= '0;
      y_r           <= '0;
      bar_idx_r     <= 3'd0;
      bar_cnt_r     <= '0;
      after_done_r  <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= BASE_ADDR;
      avm_writedata <= 32'h0000_0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          after_done_r <= 1'b0;
          if (go_s) begin
            state_r       <= WRITE;
            pattern_r     <= pattern_e'(pattern_sel);
            x_r           <= next_x_s;
            y_r           <= next_y_s;
            bar_idx_r     <= next_bar_idx_s;
            bar_cnt_r     <= next_bar_cnt_s;
            avm_write     <= 1'b1;
            avm_address   <= BASE_ADDR;
            avm_writedata <= {8'h00, rgb_s};
            busy          <= 1'b1;
          end
        end
        WRITE: begin
          if (accept_s) begin
            if (last_pixel_s) begin
              state_r     <= DONE;
              avm_write   <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else begin
              x_r           <= next_x_s;
              y_r           <= next_y_s;
              bar_idx_r     <= next_bar_idx_s;
              bar_cnt_r     <= next_bar_cnt_s;
              avm_address   <= avm_address + 32'd4;
              avm_writedata <= {8'h00, rgb_s};
            end
          end
        end
        DONE: begin
          state_r      <= IDLE;
          done         <= 1'b0;
          after_done_r <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          avm_write <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: expected pixel writes are queued when a
// frame is started and popped as the DUT's writes are accepted.
module tb_frame_writer;

  localparam int          H    = 16;
  localparam int          V    = 4;
  localparam logic [31:0] BASE = 32'h100;
  localparam int          CH   = 32;
  localparam int          CV   = 20;

  logic        sys_clk;
  logic        sys_rst;
  logic        start, cont;
  logic [1:0]  pattern_sel;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic        busy, done;
  logic [7:0]  frame_count;

  logic        c_start, c_cont;
  logic [1:0]  c_pattern_sel;
  logic [31:0] c_address, c_writedata;
  logic        c_write, c_wait;
  logic [3:0]  c_byteenable;
  logic        c_busy, c_done;
  logic [7:0]  c_frame_count;

  int total;
  int bad;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  frame_writer #(.HDISP(H), .VDISP(V), .BASE_ADDR(BASE)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .cont(cont),
    .pattern_sel(pattern_sel), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done),
    .frame_count(frame_count)
  );

  frame_writer #(.HDISP(CH), .VDISP(CV), .BASE_ADDR(BASE)) dut_c (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(c_start), .cont(c_cont),
    .pattern_sel(c_pattern_sel), .avm_address(c_address), .avm_write(c_write),
    .avm_writedata(c_writedata), .avm_byteenable(c_byteenable),
    .avm_waitrequest(c_wait), .busy(c_busy), .done(c_done),
    .frame_count(c_frame_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference colour for one pixel.
  function automatic logic [23:0] model_rgb(input int pat, input int x, input int y, input int hd);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = x[7:0];
    yb = y[7:0];
    case (pat)
      0: return 24'h808080;
      1: begin
        case (x / (hd / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2: return {xb, yb, 8'h00};
      default: return (((x / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input int hd, input int vd);
    for (int yy = 0; yy < vd; yy++) begin
      for (int xx = 0; xx < hd; xx++) begin
        exp_addr_q.push_back(BASE + 32'(4 * (yy * hd + xx)));
        exp_data_q.push_back({8'h00, model_rgb(pat, xx, yy, hd)});
      end
    end
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; start = 1'b0; cont = 1'b0; c_start = 1'b0; c_cont = 1'b0;
    avm_waitrequest = 1'b0; c_wait = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", avm_write); end
    total++; if (avm_address !== BASE) begin bad++; $display("FAIL reset_addr got=%h want=%h", avm_address, BASE); end
    total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", avm_writedata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", frame_count); end
  endtask

  task automatic test_solid();
    int writes = 0;
    int cyc = 0;
    logic [31:0] ea, ed;
    do_reset();
    push_frame(0, H, V);
    pattern_sel = 2'd0; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    total++; if (avm_write !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL solid_first_cycle write=%b busy=%b want 1 1", avm_write, busy); end
    total++; if (avm_byteenable !== 4'hF) begin bad++; $display("FAIL solid_byteenable got=%h want=f", avm_byteenable); end
    while (writes < H * V && cyc < 500) begin
      if (avm_write === 1'b1) begin
        if (done === 1'b1) begin total++; bad++; $display("FAIL solid_early_done at write %0d", writes); end
        if (exp_addr_q.size() == 0) begin total++; bad++; $display("FAIL solid_extra_write addr=%h", avm_address); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          total++; if (avm_address !== ea || avm_writedata !== ed) begin bad++; $display("FAIL solid_pixel addr=%h data=%h want addr=%h data=%h", avm_address, avm_writedata, ea, ed); end
        end
        writes++;
      end
      @(posedge sys_clk); #1; cyc++;
    end
    total++; if (writes != H * V) begin bad++; $display("FAIL solid_write_count got=%0d want=%0d", writes, H * V); end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL solid_done done=%b busy=%b want 1 0", done, busy); end
    total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL solid_count got=%0d want=1", frame_count); end
    @(posedge sys_clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL solid_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_bars_stall();
    int writes = 0;
    int cyc = 0;
    int px;
    logic pend = 1'b0;
    logic [31:0] pa, pd, ea, ed;
    do_reset();
    push_frame(1, H, V);
    pattern_sel = 2'd1; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    while (writes < H * V && cyc < 2000) begin
      if (pend) begin
        total++; if (avm_write !== 1'b1 || avm_address !== pa || avm_writedata !== pd) begin bad++; $display("FAIL bars_stall_hold write=%b addr=%h data=%h want 1 %h %h", avm_write, avm_address, avm_writedata, pa, pd); end
      end
      avm_waitrequest = 1'($urandom_range(0, 1));
      if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
        pend = 1'b0;
        px = int'((avm_address - BASE) >> 2) % H;
        if (px == 2) begin
          total++; if (avm_writedata !== 32'h00FFFF00) begin bad++; $display("FAIL bars_x2 got=%h want=00ffff00", avm_writedata); end
        end
        if (px == 15) begin
          total++; if (avm_writedata !== 32'h00000000) begin bad++; $display("FAIL bars_x15 got=%h want=00000000", avm_writedata); end
        end
        if (exp_addr_q.size() == 0) begin total++; bad++; $display("FAIL bars_extra_write addr=%h", avm_address); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          total++; if (avm_address !== ea || avm_writedata !== ed) begin bad++; $display("FAIL bars_pixel addr=%h data=%h want addr=%h data=%h", avm_address, avm_writedata, ea, ed); end
        end
        writes++;
      end else if (avm_write === 1'b1) begin
        pend = 1'b1; pa = avm_address; pd = avm_writedata;
      end else begin
        pend = 1'b0;
      end
      @(posedge sys_clk); #1; cyc++;
    end
    avm_waitrequest = 1'b0;
    total++; if (writes != H * V) begin bad++; $display("FAIL bars_write_count got=%0d want=%0d", writes, H * V); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bars_done got=%b want=1", done); end
  endtask

  task automatic test_checker();
    int writes = 0;
    int cyc = 0;
    logic [31:0] ea, ed;
    do_reset();
    push_frame(3, CH, CV);
    c_pattern_sel = 2'd3; c_start = 1'b1;
    @(posedge sys_clk); #1; c_start = 1'b0;
    while (writes < CH * CV && cyc < 2000) begin
      if (c_write === 1'b1) begin
        if (c_address === BASE + 32'(4 * 16)) begin
          total++; if (c_writedata !== 32'h00FFFFFF) begin bad++; $display("FAIL checker_16_0 got=%h want=00ffffff", c_writedata); end
        end
        if (c_address === BASE + 32'(4 * (16 * CH + 16))) begin
          total++; if (c_writedata !== 32'h00000000) begin bad++; $display("FAIL checker_16_16 got=%h want=00000000", c_writedata); end
        end
        if (exp_addr_q.size() == 0) begin total++; bad++; $display("FAIL checker_extra_write addr=%h", c_address); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          total++; if (c_address !== ea || c_writedata !== ed) begin bad++; $display("FAIL checker_pixel addr=%h data=%h want addr=%h data=%h", c_address, c_writedata, ea, ed); end
        end
        writes++;
      end
      @(posedge sys_clk); #1; cyc++;
    end
    total++; if (writes != CH * CV) begin bad++; $display("FAIL checker_write_count got=%0d want=%0d", writes, CH * CV); end
    total++; if (c_done !== 1'b1 || c_frame_count !== 8'd1) begin bad++; $display("FAIL checker_done done=%b count=%0d want 1 1", c_done, c_frame_count); end
  endtask

  task automatic test_start_busy();
    int writes = 0;
    int cyc = 0;
    logic pulsed = 1'b0;
    logic extra = 1'b0;
    logic [31:0] ea, ed;
    do_reset();
    push_frame(0, H, V);
    pattern_sel = 2'd0; start = 1'b1;
    @(posedge sys_clk); #1;
    while (writes < H * V && cyc < 500) begin
      start = 1'b0;
      if (avm_write === 1'b1) begin
        if (exp_addr_q.size() == 0) begin total++; bad++; $display("FAIL busy_extra_write addr=%h", avm_address); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          total++; if (avm_address !== ea || avm_writedata !== ed) begin bad++; $display("FAIL busy_pixel addr=%h data=%h want addr=%h data=%h", avm_address, avm_writedata, ea, ed); end
        end
        writes++;
      end
      if (writes == 10 && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
      @(posedge sys_clk); #1; cyc++;
    end
    total++; if (writes != H * V) begin bad++; $display("FAIL busy_write_count got=%0d want=%0d", writes, H * V); end
    total++; if (done !== 1'b1 || frame_count !== 8'd1) begin bad++; $display("FAIL busy_done done=%b count=%0d want 1 1", done, frame_count); end
    start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (avm_write !== 1'b0 || busy !== 1'b0) extra = 1'b1;
      @(posedge sys_clk); #1;
    end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL busy_start_at_done ignored got write seen=%b want=0", extra); end
    total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL busy_final_count got=%0d want=1", frame_count); end
  endtask

  task automatic test_cont();
    int writes = 0;
    int cyc = 0;
    int dones = 0;
    int done_cyc = 0;
    logic wait_first = 1'b0;
    logic [31:0] ea, ed;
    do_reset();
    for (int f = 0; f < 257; f++) push_frame(2, H, V);
    pattern_sel = 2'd2; cont = 1'b1; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    while (dones < 257 && cyc < 30000) begin
      if (avm_write === 1'b1) begin
        if (wait_first) begin
          total++; if (cyc != done_cyc + 2) begin bad++; $display("FAIL cont_gap first write %0d cycles after done want 2", cyc - done_cyc); end
          wait_first = 1'b0;
        end
        if (exp_addr_q.size() == 0) begin total++; bad++; $display("FAIL cont_extra_write addr=%h", avm_address); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          total++; if (avm_address !== ea || avm_writedata !== ed) begin bad++; $display("FAIL cont_pixel addr=%h data=%h want addr=%h data=%h", avm_address, avm_writedata, ea, ed); end
        end
        writes++;
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc = cyc;
        wait_first = 1'b1;
        total++; if (frame_count !== 8'(dones)) begin bad++; $display("FAIL cont_count frame=%0d got=%0d want=%0d", dones, frame_count, dones % 256); end
        if (dones == 257) cont = 1'b0;
      end
      @(posedge sys_clk); #1; cyc++;
    end
    total++; if (dones != 257 || writes != 257 * H * V) begin bad++; $display("FAIL cont_frames dones=%0d writes=%0d want 257 %0d", dones, writes, 257 * H * V); end
    repeat (4) @(posedge sys_clk);
    #1;
    total++; if (avm_write !== 1'b0 || frame_count !== 8'd1) begin bad++; $display("FAIL cont_stop write=%b count=%0d want 0 1", avm_write, frame_count); end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    int cyc = 0;
    logic [31:0] ea, ed;
    do_reset();
    push_frame(0, H, V);
    pattern_sel = 2'd0; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    while (writes < 30 && cyc < 500) begin
      if (avm_write === 1'b1) begin
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        total++; if (avm_address !== ea || avm_writedata !== ed) begin bad++; $display("FAIL rstmid_pixel addr=%h data=%h want addr=%h data=%h", avm_address, avm_writedata, ea, ed); end
        writes++;
      end
      if (writes < 30) begin @(posedge sys_clk); #1; cyc++; end
    end
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    total++; if (avm_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_abort write=%b busy=%b want 0 0", avm_write, busy); end
    exp_addr_q.delete(); exp_data_q.delete();
    push_frame(2, H, V);
    pattern_sel = 2'd2; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
    total++; if (avm_write !== 1'b1 || avm_address !== ea || avm_writedata !== ed) begin bad++; $display("FAIL rstmid_restart write=%b addr=%h data=%h want 1 %h %h", avm_write, avm_address, avm_writedata, ea, ed); end
    do_reset();
  endtask

  initial begin
    total = 0; bad = 0;
    sys_rst = 1'b1; start = 1'b0; cont = 1'b0; pattern_sel = 2'd0; avm_waitrequest = 1'b0;
    c_start = 1'b0; c_cont = 1'b0; c_pattern_sel = 2'd0; c_wait = 1'b0;
    test_reset();
    test_solid();
    test_bars_stall();
    test_checker();
    test_start_busy();
    test_cont();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Avalon-MM write master in the `sys_clk` domain that fills the SDRAM framebuffer with a selectable test pattern, one 32-bit word per pixel. It sits upstream of the SDRAM interconnect, in place of the video stream host, and produces the frame that the VGA controller later reads back and displays. It gives the display path a known image before the real video source is connected.

## Interface
Parameters:
- `HDISP`, 800: active pixels per line; must be a multiple of 8.
- `VDISP`, 480: active lines per frame.
- `BASE_ADDR`, 32'h0000_0000: byte address of pixel (0,0); must be 4-byte aligned.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` in 1: system clock, 100 MHz.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to write one frame.
- `cont` in 1: when 1, a new frame starts automatically after each `done`.
- `pattern_sel` in 2: pattern select, sampled when a frame starts.
- `avm_address` out 32: byte address.
- `avm_write` out 1: write request.
- `avm_writedata` out 32: pixel word {8'h00, R, G, B}.
- `avm_byteenable` out 4: always 4'hF.
- `avm_waitrequest` in 1: slave stall.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse after the last pixel is accepted.
- `frame_count` out 8: number of completed frames; wraps modulo 256.

## Operation
- FSM states and transitions:
  - IDLE to WRITE when `start` is high, or when `cont` is high on the cycle after `done`.
  - WRITE to DONE when the last pixel is accepted.
  - DONE to IDLE after one cycle.
- Pixel counters:
  - `x` counts 0..HDISP-1 and `y` counts 0..VDISP-1, raster order.
  - They advance only on acceptance, i.e. `avm_write & ~avm_waitrequest`.
- Address: kept as a running byte pointer = BASE_ADDR + 4·(y·HDISP + x). It adds 4 per acceptance, so no multiplier is used.
- Avalon rule: while `avm_waitrequest` is high, `avm_write`, `avm_address` and `avm_writedata` hold stable.
- `pattern_sel` is latched when entering WRITE.
  - 0 = solid gray, 24'h808080.
  - 1 = 8 vertical bars, each HDISP/8 wide. A bar sub-counter is used, not a divider. Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 2 = gradient with R = x[7:0], G = y[7:0], B = 8'h00.
  - 3 = 16-pixel checkerboard: FFFFFF when x[4]^y[4], else 000000.
- Boundary behaviour:
  - `start` while `busy` is ignored.
  - `start` in the same cycle as `done` is ignored. `cont` covers back-to-back frames.
  - `frame_count` increments in the DONE cycle. 255 wraps to 0.
  - `sys_rst` mid-frame returns to IDLE at the next edge. The partial frame is abandoned and the next start begins again at BASE_ADDR.

## Timing
- Reset values:
  - `avm_write` = 0, `avm_address` = BASE_ADDR, `avm_writedata` = 0.
  - `busy` = 0, `done` = 0, `frame_count` = 0.
- `start` high in cycle N gives `avm_write` = 1 with `avm_address` = BASE_ADDR and pixel (0,0) data in cycle N+1. `busy` also rises in N+1.
- All outputs are registered. Next-pixel data is computed when the current pixel is accepted, so it is ready in the following cycle.
- With `avm_waitrequest` tied to 0, one pixel is accepted per cycle. The frame takes HDISP·VDISP write cycles.
- `done` is high in the cycle after the last acceptance. `busy` falls in that same cycle.
- In `cont` mode the next frame's first write is asserted 2 cycles after `done`.

## Structure
- Package `frame_writer_pkg` holds:
  - `pattern_e` (SOLID, BARS, GRADIENT, CHECKER).
  - `state_e` (IDLE, WRITE, DONE).
  - The eight 24-bit bar colour constants.
  - The gray constant.
- Sub-module `pattern_gen` computes the RGB value from x, y, bar index and the latched pattern.
- `frame_writer` holds the FSM, the counters and the Avalon master logic.

## Test plan
Bench settings: HDISP=16, VDISP=4, BASE_ADDR=32'h100.
- Pattern 0, `waitrequest` = 0, pulse `start` → 64 writes to addresses 0x100..0x1FC, all data 32'h00808080. `done` fires 1 cycle after the 64th write; `frame_count` = 1.
- Pattern 1, random `waitrequest` → address and data stay stable during every stall. Pixel x=2 gives FFFF00 and pixel x=15 gives 000000 on every line.
- Pattern 3 with HDISP=32 → pixel (16,0) is 00FFFFFF and pixel (16,16) is 00000000, with VDISP=20 so line 16 exists.
- `start` pulsed while busy at write 10 → the frame still has exactly 64 writes and `frame_count` = 1.
- `cont` = 1 held for 257 frames → the first write of each frame comes 2 cycles after `done`, and `frame_count` wraps from 255 to 0 and then reads 1.
- `sys_rst` at write 30 → `avm_write` = 0 at the next edge. A new `start` writes 0x100 first.
